// File: rtl/ov7670_capture_pkg.sv
// rtl/ov7670_capture_pkg.sv - shared constants and types for the OV7670 capture path
// FSM encoding, RGB332 field widths and default active-area size shared with vga640x480.
package ov7670_capture_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  localparam int R_W = 3;
  localparam int G_W = 3;
  localparam int B_W = 2;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    LINE       = 2'd1,
    HI         = 2'd2,
    LO         = 2'd3
  } cap_state_t;

endpackage

// File: rtl/ov7670_capture_rgb565_to_rgb332.sv
// rtl/ov7670_capture_rgb565_to_rgb332.sv - combinational RGB565 byte pair to RGB332 pack
// hi = R4..R0 G5..G3, lo = G2..G0 B4..B0; keeps the most significant bits of each field.
module rgb565_to_rgb332
  import ov7670_capture_pkg::*;
(
  input  logic [7:0] hi,
  input  logic [7:0] lo,
  output logic [7:0] pix
);

  logic [R_W-1:0] r;
  logic [G_W-1:0] g;
  logic [B_W-1:0] b;
  logic           pack_unused;

  assign r   = hi[7 -: R_W];
  assign g   = hi[2:0];
  assign b   = lo[4 -: B_W];
  assign pix = {r, g, b};

  assign pack_unused = ^{hi[4:3], lo[7:5], lo[2:0]};

endmodule

// File: rtl/ov7670_capture.sv
// rtl/ov7670_capture.sv - OV7670 RGB565 capture to RGB332 frame-buffer writes
// Optional CAPTURE_DECIMATE_EN: 2:1 decimation in H and V (even pixels of even lines only).
module ov7670_capture
  import ov7670_capture_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int ADDR_W   = 19
) (
  input  logic              dclk,
  input  logic              clr,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_d,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              frame_done,
  output logic              busy
);

  localparam int PW = $clog2(H_ACTIVE + 1);
  localparam int LW = $clog2(V_ACTIVE + 1);
  localparam logic [PW-1:0] H_LIM = PW'(H_ACTIVE);
  localparam logic [LW-1:0] V_LIM = LW'(V_ACTIVE);
`ifdef CAPTURE_DECIMATE_EN
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE / 2);
`else
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE);
`endif

  cap_state_t        state, state_nx;
  logic              vsync_r, href_r, vsync_q;
  logic [7:0]        d_r, hi_byte, hi_byte_nx, pix_packed;
  logic [PW-1:0]     pix_cnt, pix_cnt_nx;
  logic [LW-1:0]     line_cnt, line_cnt_nx;
  logic [ADDR_W-1:0] line_base, line_base_nx, pix_addr, wr_addr_nx;
  logic [7:0]        wr_data_nx;
  logic              wr_en_nx, frame_done_nx;
  logic              vs_fall, vs_rise, pix_ok, line_step_en;

  assign vs_fall = vsync_q & ~vsync_r;
  assign vs_rise = ~vsync_q & vsync_r;
  assign busy    = (state != WAIT_FRAME);

  // line_base tracks line*line_width so the address needs only an adder
`ifdef CAPTURE_DECIMATE_EN
  assign pix_ok       = (pix_cnt < H_LIM) && (line_cnt < V_LIM) && !pix_cnt[0] && !line_cnt[0];
  assign pix_addr     = line_base + ADDR_W'(pix_cnt >> 1);
  assign line_step_en = line_cnt[0] && (line_cnt < V_LIM - 1'b1);
`else
  assign pix_ok       = (pix_cnt < H_LIM) && (line_cnt < V_LIM);
  assign pix_addr     = line_base + ADDR_W'(pix_cnt);
  assign line_step_en = (line_cnt < V_LIM - 1'b1);
`endif

  rgb565_to_rgb332 u_pack (
    .hi  (hi_byte),
    .lo  (d_r),
    .pix (pix_packed)
  );

  always_ff @(posedge dclk) begin
    if (clr) begin
      state <= WAIT_FRAME;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      WAIT_FRAME: if (vs_fall) state_nx = LINE;
      LINE, HI: begin
        if (vs_rise)     state_nx = WAIT_FRAME;
        else if (href_r) state_nx = LO;
        else             state_nx = LINE;
      end
      LO: begin
        if (vs_rise)     state_nx = WAIT_FRAME;
        else if (href_r) state_nx = HI;
        else             state_nx = LINE;
      end
      default: state_nx = WAIT_FRAME;
    endcase
  end

  always_comb begin
    pix_cnt_nx    = pix_cnt;
    line_cnt_nx   = line_cnt;
    line_base_nx  = line_base;
    hi_byte_nx    = hi_byte;
    wr_en_nx      = 1'b0;
    wr_addr_nx    = wr_addr;
    wr_data_nx    = wr_data;
    frame_done_nx = 1'b0;
    case (state)
      WAIT_FRAME: begin
        if (vs_fall) begin
          pix_cnt_nx   = '0;
          line_cnt_nx  = '0;
          line_base_nx = '0;
        end
      end
      LINE, HI, LO: begin
        if (vs_rise) begin
          frame_done_nx = 1'b1;
        end else if (href_r) begin
          if (state == LO) begin
            if (pix_ok) begin
              wr_en_nx   = 1'b1;
              wr_addr_nx = pix_addr;
              wr_data_nx = pix_packed;
            end
            if (pix_cnt != H_LIM) pix_cnt_nx = pix_cnt + 1'b1;
          end else begin
            hi_byte_nx = d_r;
          end
        end else if (state != LINE) begin
          // end of line; an unpaired hi byte is simply never used
          pix_cnt_nx = '0;
          if (pix_cnt != '0 && line_cnt != V_LIM) begin
            line_cnt_nx = line_cnt + 1'b1;
            if (line_step_en) line_base_nx = line_base + LINE_STEP;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge dclk) begin
    if (clr) begin
      vsync_r    <= 1'b0;
      vsync_q    <= 1'b0;
      href_r     <= 1'b0;
      d_r        <= '0;
      hi_byte    <= '0;
      pix_cnt    <= '0;
      line_cnt   <= '0;
      line_base  <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
    end else begin
      vsync_r    <= cam_vsync;
      vsync_q    <= vsync_r;
      href_r     <= cam_href;
      d_r        <= cam_d;
      hi_byte    <= hi_byte_nx;
      pix_cnt    <= pix_cnt_nx;
      line_cnt   <= line_cnt_nx;
      line_base  <= line_base_nx;
      wr_en      <= wr_en_nx;
      wr_addr    <= wr_addr_nx;
      wr_data    <= wr_data_nx;
      frame_done <= frame_done_nx;
    end
  end

endmodule

// File: tb/tb_ov7670_capture.sv
// tb/tb_ov7670_capture.sv - scoreboard testbench for ov7670_capture
// Expected writes are modelled per pixel as bytes are driven and popped as wr_en strobes appear.
module tb_ov7670_capture;

`ifdef CAPTURE_DECIMATE_EN
  localparam int H   = 8;
  localparam bit DEC = 1'b1;
`else
  localparam int H   = 640;
  localparam bit DEC = 1'b0;
`endif
  localparam int V  = 4;
  localparam int AW = 19;

  logic          dclk = 1'b0;
  logic          clr = 1'b1;
  logic          cam_vsync = 1'b0;
  logic          cam_href = 1'b0;
  logic [7:0]    cam_d = 8'h00;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          frame_done;
  logic          busy;

  always #5 dclk = ~dclk;

  ov7670_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
    .dclk       (dclk),
    .clr        (clr),
    .cam_vsync  (cam_vsync),
    .cam_href   (cam_href),
    .cam_d      (cam_d),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_done (frame_done),
    .busy       (busy)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  wr_t           sb[$];
  int            tests_run = 0;
  int            tests_failed = 0;
  int            wr_seen = 0;
  int            fd_seen = 0;
  logic          fd_prev = 1'b0;
  logic [AW-1:0] last_addr = '0;
  logic [7:0]    last_data = '0;
  int            m_line = 0;
  int            m_pix = 0;
  bit            m_armed = 1'b0;

  always @(negedge dclk) begin
    if (wr_en) begin
      wr_t e;
      wr_seen++;
      last_addr = wr_addr;
      last_data = wr_data;
      tests_run++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write", wr_addr, wr_data);
      end else begin
        e = sb.pop_front();
        if ({wr_addr, wr_data} !== {e.addr, e.data}) begin
          tests_failed++;
          $display("FAIL write: got addr=%0d data=%h, expected addr=%0d data=%h",
                   wr_addr, wr_data, e.addr, e.data);
        end
      end
    end
    if (frame_done) begin
      fd_seen++;
      tests_run++;
      if (fd_prev) begin
        tests_failed++;
        $display("FAIL frame_done_width: got high for 2+ cycles, expected 1");
      end
    end
    fd_prev = frame_done;
  end

  task automatic drive(input logic v, input logic h, input logic [7:0] d);
    @(posedge dclk);
    #1;
    cam_vsync = v;
    cam_href  = h;
    cam_d     = d;
  endtask

  task automatic send_pixel(input logic [7:0] hi, input logic [7:0] lo);
    int addr;
    drive(1'b0, 1'b1, hi);
    drive(1'b0, 1'b1, lo);
    if (m_armed && m_pix < H && m_line < V && (!DEC || (m_pix % 2 == 0 && m_line % 2 == 0))) begin
      addr = DEC ? (m_line / 2) * (H / 2) + m_pix / 2 : m_line * H + m_pix;
      sb.push_back({AW'(addr), hi[7:5], hi[2:0], lo[4:3]});
    end
    m_pix++;
  endtask

  task automatic end_line();
    repeat (4) drive(1'b0, 1'b0, 8'h00);
    if (m_pix > 0) m_line++;
    m_pix = 0;
  endtask

  task automatic send_line(input int npix, input bit stray);
    for (int i = 0; i < npix; i++) send_pixel(8'($urandom), 8'($urandom));
    if (stray) drive(1'b0, 1'b1, 8'($urandom));
    end_line();
  endtask

  task automatic start_frame();
    repeat (3) drive(1'b1, 1'b0, 8'h00);
    repeat (3) drive(1'b0, 1'b0, 8'h00);
    m_line  = 0;
    m_pix   = 0;
    m_armed = 1'b1;
  endtask

  task automatic end_frame(input string name);
    int fd0;
    fd0 = fd_seen;
    repeat (3) drive(1'b1, 1'b0, 8'h00);
    repeat (3) drive(1'b1, 1'b0, 8'h00);
    m_armed = 1'b0;
    tests_run++;
    if (fd_seen - fd0 !== 1) begin
      tests_failed++;
      $display("FAIL %s_frame_done: got %0d pulses, expected 1", name, fd_seen - fd0);
    end
    tests_run++;
    if (sb.size() !== 0) begin
      tests_failed++;
      $display("FAIL %s_missing_writes: got %0d outstanding, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    clr = 1'b1;
    repeat (2) @(posedge dclk);
    #1;
    tests_run++;
    if ({wr_en, wr_addr, wr_data, frame_done, busy} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got en=%b addr=%0d data=%h fd=%b busy=%b, expected all 0",
               wr_en, wr_addr, wr_data, frame_done, busy);
    end
    clr = 1'b0;
  endtask

  task automatic test_single_pixel();
    int w0;
    start_frame();
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL busy_in_frame: got %b, expected 1", busy);
    end
    w0 = wr_seen;
    send_pixel(8'hF8, 8'h1F);
    end_line();
    tests_run++;
    if (wr_seen - w0 !== 1 || last_addr !== '0 || last_data !== 8'hE3) begin
      tests_failed++;
      $display("FAIL single_pixel: got %0d writes addr=%0d data=%h, expected 1 write addr=0 data=e3",
               wr_seen - w0, last_addr, last_data);
    end
    end_frame("single");
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL busy_after_frame: got %b, expected 0", busy);
    end
  endtask

  task automatic test_full_lines();
    int w0;
    start_frame();
    w0 = wr_seen;
    repeat (3) send_line(H, 1'b0);
    tests_run++;
    if (wr_seen - w0 !== (DEC ? H : 3 * H)) begin
      tests_failed++;
      $display("FAIL full_lines_count: got %0d, expected %0d", wr_seen - w0, DEC ? H : 3 * H);
    end
    tests_run++;
    if (last_addr !== AW'(DEC ? H - 1 : 3 * H - 1)) begin
      tests_failed++;
      $display("FAIL full_lines_last_addr: got %0d, expected %0d", last_addr, DEC ? H - 1 : 3 * H - 1);
    end
    end_frame("full");
  endtask

  task automatic test_long_line();
    int w0;
    start_frame();
    w0 = wr_seen;
    send_line(H + (DEC ? 5 : 60), 1'b0);
    tests_run++;
    if (wr_seen - w0 !== (DEC ? H / 2 : H) || last_addr !== AW'(DEC ? H / 2 - 1 : H - 1)) begin
      tests_failed++;
      $display("FAIL long_line: got %0d writes last=%0d, expected %0d writes last=%0d",
               wr_seen - w0, last_addr, DEC ? H / 2 : H, DEC ? H / 2 - 1 : H - 1);
    end
    send_line(2, 1'b0);
    send_line(2, 1'b0);
    tests_run++;
    if (last_addr !== AW'(DEC ? H / 2 : 2 * H + 1)) begin
      tests_failed++;
      $display("FAIL after_long_line: got last=%0d, expected %0d", last_addr, DEC ? H / 2 : 2 * H + 1);
    end
    end_frame("long");
  endtask

  task automatic test_odd_bytes();
    int w0;
    start_frame();
    w0 = wr_seen;
    send_line(1, 1'b1);
    tests_run++;
    if (wr_seen - w0 !== 1) begin
      tests_failed++;
      $display("FAIL odd_bytes_count: got %0d, expected 1", wr_seen - w0);
    end
    send_line(1, 1'b0);
    send_line(1, 1'b0);
    tests_run++;
    if (last_addr !== AW'(DEC ? H / 2 : 2 * H)) begin
      tests_failed++;
      $display("FAIL odd_bytes_next_line: got %0d, expected %0d", last_addr, DEC ? H / 2 : 2 * H);
    end
    end_frame("odd");
  endtask

  task automatic test_line_limit();
    int w0;
    start_frame();
    w0 = wr_seen;
    repeat (V + 2) send_line(4, 1'b0);
    tests_run++;
    if (wr_seen - w0 !== (DEC ? 4 : 4 * V)) begin
      tests_failed++;
      $display("FAIL line_limit_count: got %0d, expected %0d", wr_seen - w0, DEC ? 4 : 4 * V);
    end
    tests_run++;
    if (last_addr !== AW'(DEC ? H / 2 + 1 : (V - 1) * H + 3)) begin
      tests_failed++;
      $display("FAIL line_limit_last: got %0d, expected %0d", last_addr, DEC ? H / 2 + 1 : (V - 1) * H + 3);
    end
    end_frame("limit");
  endtask

  task automatic test_short_frame_partial();
    int w0;
    start_frame();
    w0 = wr_seen;
    send_pixel(8'h12, 8'h34);
    send_pixel(8'h56, 8'h78);
    drive(1'b0, 1'b1, 8'hAB);
    drive(1'b1, 1'b1, 8'hCD);
    end_frame("partial");
    tests_run++;
    if (wr_seen - w0 !== (DEC ? 1 : 2)) begin
      tests_failed++;
      $display("FAIL partial_pixel_dropped: got %0d writes, expected %0d", wr_seen - w0, DEC ? 1 : 2);
    end
  endtask

  task automatic test_clr_mid_frame();
    int w0;
    int fd0;
    start_frame();
    send_line(6, 1'b0);
    send_pixel(8'hF0, 8'h0F);
    send_pixel(8'h0F, 8'hF0);
    drive(1'b0, 1'b1, 8'h55);
    @(posedge dclk);
    #1;
    clr = 1'b1;
    @(posedge dclk);
    #1;
    tests_run++;
    if ({wr_en, wr_addr, wr_data, frame_done, busy} !== '0) begin
      tests_failed++;
      $display("FAIL clr_outputs: got en=%b addr=%0d data=%h fd=%b busy=%b, expected all 0",
               wr_en, wr_addr, wr_data, frame_done, busy);
    end
    clr = 1'b0;
    m_armed = 1'b0;
    tests_run++;
    if (sb.size() !== 0) begin
      tests_failed++;
      $display("FAIL clr_pre_writes: got %0d outstanding, expected 0", sb.size());
      sb.delete();
    end
    w0  = wr_seen;
    fd0 = fd_seen;
    send_line(5, 1'b0);
    send_line(5, 1'b0);
    repeat (4) drive(1'b1, 1'b0, 8'h00);
    tests_run++;
    if (wr_seen - w0 !== 0 || fd_seen - fd0 !== 0) begin
      tests_failed++;
      $display("FAIL clr_idle: got %0d writes %0d frame_done, expected 0 and 0", wr_seen - w0, fd_seen - fd0);
    end
    start_frame();
    send_line(4, 1'b0);
    tests_run++;
    if (last_addr !== AW'(DEC ? 1 : 3)) begin
      tests_failed++;
      $display("FAIL clr_restart: got last=%0d, expected %0d", last_addr, DEC ? 1 : 3);
    end
    end_frame("restart");
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_full_lines();
    test_long_line();
    test_odd_bytes();
    test_line_limit();
    test_short_frame_partial();
    test_clr_mid_frame();
    repeat (4) @(posedge dclk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
